// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART-side stream blocks.
//   byte_t       : one 8-bit stream beat
//   arb_state_t  : arbiter FSM states (ST_TAG is only reachable when the
//                  arbiter is built with UART_ARB_TAG_EN)
//   TAG_NIBBLE   : upper nibble of the per-message header byte
//   tag_byte()   : builds the header byte {TAG_NIBBLE, id}
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_TAG  = 2'b01,
        ST_DATA = 2'b10
    } arb_state_t;

    localparam logic [3:0] TAG_NIBBLE = 4'hF;

    // Header byte announcing which source owns the following message.
    function automatic byte_t tag_byte(input logic [3:0] id);
        return {TAG_NIBBLE, id};
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// -----------------------------------------------------------------------------
// uart_rr_picker
// Combinational round-robin picker. Finds the first asserted request bit
// searching upward from last+1, wrapping modulo NUM_SRC.
// Ports:
//   req   [NUM_SRC] : request vector
//   last  [ID_W]    : index granted most recently (search starts after it)
//   found           : at least one request is asserted
//   idx   [ID_W]    : selected index (0 when found is low)
// -----------------------------------------------------------------------------
module uart_rr_picker
    import uart_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic               found,
    output logic [ID_W-1:0]    idx
);

    localparam logic [ID_W:0] NUM_SRC_W = (ID_W+1)'(NUM_SRC);

    // Scan from the farthest distance down to the nearest so that the
    // closest requester after 'last' is the one left in idx.
    always_comb begin : scan
        logic [ID_W:0]   sum_s;
        logic [ID_W-1:0] cand_s;
        found  = 1'b0;
        idx    = '0;
        sum_s  = '0;
        cand_s = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            sum_s  = {1'b0, last} + (ID_W+1)'(k);
            sum_s  = (sum_s >= NUM_SRC_W) ? (sum_s - NUM_SRC_W) : sum_s;
            cand_s = sum_s[ID_W-1:0];
            found  = found | req[cand_s];
            idx    = req[cand_s] ? cand_s : idx;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin, packet-locked arbiter sharing one uart_tx byte stream among
// NUM_SRC AXI-Stream byte producers. A granted source keeps the UART until
// its tlast beat is accepted, so messages never interleave.
//
// Build option:
//   UART_ARB_TAG_EN  defined   -> every message is preceded by header byte
//                                 0xF0|id (TAG state compiled in)
//                    undefined -> output stream is exactly the source bytes
//
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   s_axis_tvalid[N]     per-source valid
//   s_axis_tdata[N*8]    per-source byte, source i at [8i+7:8i]
//   s_axis_tlast[N]      per-source end-of-message
//   s_axis_tready[N]     per-source ready (one-hot or zero)
//   m_axis_tvalid/tdata  byte stream toward uart_tx
//   m_axis_tready        ready from uart_tx
//   grant_id[ID_W]       current or last granted source
//   busy                 high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [NUM_SRC-1:0]   s_axis_tvalid,
    input  logic [NUM_SRC*8-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]   s_axis_tlast,
    output logic [NUM_SRC-1:0]   s_axis_tready,
    output logic                 m_axis_tvalid,
    output logic [7:0]           m_axis_tdata,
    input  logic                 m_axis_tready,
    output logic [ID_W-1:0]      grant_id,
    output logic                 busy
);

    // After reset the search must start at source 0.
    localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_SRC - 1);

    arb_state_t          state_r;
    logic [ID_W-1:0]     grant_r;
    logic [ID_W-1:0]     last_grant_r;
    logic                busy_r;

    byte_t               src_byte_s [NUM_SRC];
    logic                pick_found_s;
    logic [ID_W-1:0]     pick_idx_s;
    logic                msg_end_s;

    logic                m_tvalid_s;
    byte_t               m_tdata_s;
    logic [NUM_SRC-1:0]  s_tready_s;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign src_byte_s[g] = s_axis_tdata[8*g +: 8];
    end

    uart_rr_picker #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_picker (
        .req   (s_axis_tvalid),
        .last  (last_grant_r),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // Message ends when the granted source's tlast beat is accepted.
    assign msg_end_s = (state_r == ST_DATA) && s_axis_tvalid[grant_r] &&
                       s_axis_tlast[grant_r] && m_axis_tready;

    // Grant FSM: registered arbitration decision and packet lock.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r      <= ST_IDLE;
            grant_r      <= '0;
            last_grant_r <= LAST_RST;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        grant_r      <= pick_idx_s;
                        last_grant_r <= pick_idx_s;
                        busy_r       <= 1'b1;
`ifdef UART_ARB_TAG_EN
                        state_r      <= ST_TAG;
`else
                        state_r      <= ST_DATA;
`endif
                    end else begin
                        state_r      <= ST_IDLE;
                        busy_r       <= 1'b0;
                    end
                end
`ifdef UART_ARB_TAG_EN
                ST_TAG: begin
                    if (m_axis_tready) begin
                        state_r <= ST_DATA;
                    end else begin
                        state_r <= ST_TAG;
                    end
                end
`endif
                ST_DATA: begin
                    if (msg_end_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_DATA;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Stream mux: m_axis_tvalid depends only on state and the granted
    // source, never on m_axis_tready; ready is routed back only in DATA.
    always_comb begin
        m_tvalid_s = 1'b0;
        m_tdata_s  = 8'h00;
        s_tready_s = '0;
        case (state_r)
            ST_IDLE: begin
                m_tvalid_s = 1'b0;
            end
`ifdef UART_ARB_TAG_EN
            ST_TAG: begin
                m_tvalid_s = 1'b1;
                m_tdata_s  = tag_byte(4'(grant_r));
            end
`endif
            ST_DATA: begin
                m_tvalid_s          = s_axis_tvalid[grant_r];
                m_tdata_s           = src_byte_s[grant_r];
                s_tready_s[grant_r] = m_axis_tready;
            end
            default: begin
                m_tvalid_s = 1'b0;
            end
        endcase
    end

    assign m_axis_tvalid = m_tvalid_s;
    assign m_axis_tdata  = m_tdata_s;
    assign s_axis_tready = s_tready_s;
    assign grant_id      = grant_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed scenarios followed by randomized rounds. Each source holds a list
// of messages; the expected output stream is derived at message level
// (round-robin over sources that still have messages) and compared beat by
// beat. Works with or without UART_ARB_TAG_EN.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NUM_SRC = 4;
    localparam int ID_W    = 2;
`ifdef UART_ARB_TAG_EN
    localparam int TAGC    = 1;
`else
    localparam int TAGC    = 0;
`endif

    logic                 aclk;
    logic                 aresetn;
    logic [NUM_SRC-1:0]   s_axis_tvalid;
    logic [NUM_SRC*8-1:0] s_axis_tdata;
    logic [NUM_SRC-1:0]   s_axis_tlast;
    logic [NUM_SRC-1:0]   s_axis_tready;
    logic                 m_axis_tvalid;
    logic [7:0]           m_axis_tdata;
    logic                 m_axis_tready;
    logic [ID_W-1:0]      grant_id;
    logic                 busy;

    uart_tx_arbiter #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tready (m_axis_tready),
        .grant_id      (grant_id),
        .busy          (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks   = 0;
    int failures = 0;

    // Per-source message storage: bit 8 = tlast, bits 7:0 = byte.
    logic [8:0] src_mem [NUM_SRC][128];
    int         src_len [NUM_SRC];
    int         src_pos [NUM_SRC];
    bit         held    [NUM_SRC];

    // Expected stream entries: {last, is_tag, src[3:0], byte[7:0]}.
    logic [13:0] exp_q[$];
    int          model_last;
    int          n_msgs;
    int          beats_out;
    int          bp_cnt;
    int          mode;
    bit          expect_bubble;
    bit          hold_prev;
    logic [7:0]  prev_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic add_byte(input int s, input logic [7:0] d, input bit last);
        src_mem[s][src_len[s]] = {last, d};
        src_len[s]++;
    endtask

    // Message-level reference: round-robin over sources with messages left.
    task automatic build_expected();
        int         ptr [NUM_SRC];
        int         pick;
        int         c;
        bit         found;
        logic [8:0] b;
        n_msgs = 0;
        for (int i = 0; i < NUM_SRC; i++) ptr[i] = src_pos[i];
        for (int guard = 0; guard < 256; guard++) begin
            found = 1'b0;
            pick  = 0;
            for (int k = 1; k <= NUM_SRC; k++) begin
                c = (model_last + k) % NUM_SRC;
                if (!found && ptr[c] < src_len[c]) begin
                    found = 1'b1;
                    pick  = c;
                end
            end
            if (!found) break;
            n_msgs++;
`ifdef UART_ARB_TAG_EN
            exp_q.push_back({1'b0, 1'b1, 4'(pick), 8'hF0 | 8'(pick)});
`endif
            do begin
                b = src_mem[pick][ptr[pick]];
                ptr[pick]++;
                exp_q.push_back({b[8], 1'b0, 4'(pick), b[7:0]});
            end while (!b[8] && ptr[pick] < src_len[pick]);
            model_last = pick;
        end
    endtask

    // One clock: drive at negedge, check at negedge+1, advance after posedge.
    task automatic step();
        logic [NUM_SRC-1:0] fire;
        logic [NUM_SRC-1:0] exp_rdy;
        logic [13:0]        e;
        bit                 mid;
        bit                 v;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_pos[i] < src_len[i]) begin
                mid = 1'b0;
                if (src_pos[i] > 0) mid = !src_mem[i][src_pos[i]-1][8];
                if (held[i]) v = 1'b1;
                else v = !(mode == 1 && mid && $urandom_range(0, 3) == 0);
                s_axis_tvalid[i]       = v;
                s_axis_tdata[8*i +: 8] = src_mem[i][src_pos[i]][7:0];
                s_axis_tlast[i]        = src_mem[i][src_pos[i]][8];
            end else begin
                s_axis_tvalid[i]       = 1'b0;
                s_axis_tdata[8*i +: 8] = 8'($urandom);
                s_axis_tlast[i]        = 1'($urandom_range(0, 1));
            end
        end
        case (mode)
            1: m_axis_tready = ($urandom_range(0, 3) != 0);
            2: begin
                if (beats_out == 1 && bp_cnt < 5) begin
                    m_axis_tready = 1'b0;
                    bp_cnt++;
                end else begin
                    m_axis_tready = 1'b1;
                end
            end
            default: m_axis_tready = 1'b1;
        endcase
        #1;
        if (expect_bubble) begin
            chk("bubble_tvalid", 32'(m_axis_tvalid), 32'd0);
            chk("bubble_busy", 32'(busy), 32'd0);
            expect_bubble = 1'b0;
        end
        if (hold_prev) begin
            chk("hold_tvalid", 32'(m_axis_tvalid), 32'd1);
            chk("hold_tdata", 32'(m_axis_tdata), 32'(prev_data));
        end
        fire = s_axis_tvalid & s_axis_tready;
        if (m_axis_tvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_tvalid", 32'(m_axis_tvalid), 32'd0);
            end else begin
                e = exp_q[0];
                chk("tdata", 32'(m_axis_tdata), 32'(e[7:0]));
                chk("grant_id", 32'(grant_id), 32'(e[11:8]));
                chk("busy_active", 32'(busy), 32'd1);
                exp_rdy = (!e[12] && m_axis_tready) ? (NUM_SRC'(1) << e[11:8]) : '0;
                chk("s_tready", 32'(s_axis_tready), 32'(exp_rdy));
                if (m_axis_tready) begin
                    void'(exp_q.pop_front());
                    if (!e[12]) beats_out++;
                    if (e[13]) expect_bubble = 1'b1;
                end
            end
        end
        hold_prev = (m_axis_tvalid === 1'b1) && !m_axis_tready;
        prev_data = m_axis_tdata;
        @(posedge aclk);
        @(negedge aclk);
        for (int i = 0; i < NUM_SRC; i++) begin
            held[i] = s_axis_tvalid[i] && !fire[i];
            if (fire[i]) src_pos[i]++;
        end
    endtask

    task automatic run(input string name, input int budget);
        int cycles;
        int exp_cycles;
        build_expected();
        exp_cycles    = n_msgs + exp_q.size();
        beats_out     = 0;
        bp_cnt        = 0;
        cycles        = 0;
        expect_bubble = 1'b1;
        while (exp_q.size() > 0 && cycles < budget) begin
            step();
            cycles++;
        end
        chk({name, "_done"}, 32'(exp_q.size()), 32'd0);
        if (mode != 1) chk({name, "_cycles"}, 32'(cycles), 32'(exp_cycles + bp_cnt));
        step();
        chk({name, "_idle_busy"}, 32'(busy), 32'd0);
        for (int i = 0; i < NUM_SRC; i++)
            chk({name, "_consumed"}, 32'(src_pos[i]), 32'(src_len[i]));
        exp_q.delete();
    endtask

    task automatic do_reset();
        aresetn       = 1'b0;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
        chk("rst_tready", 32'(s_axis_tready), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        model_last    = NUM_SRC - 1;
        expect_bubble = 1'b0;
        hold_prev     = 1'b0;
        exp_q.delete();
        for (int i = 0; i < NUM_SRC; i++) held[i] = 1'b0;
    endtask

    initial begin
        int nm;
        int len;
        mode = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
            held[i]    = 1'b0;
        end

        // Source 0 three-byte message at full throughput.
        do_reset();
        add_byte(0, 8'h41, 1'b0);
        add_byte(0, 8'h42, 1'b0);
        add_byte(0, 8'h43, 1'b1);
        run("t1", 50);
        chk("t1_grant", 32'(grant_id), 32'd0);

        // Simultaneous requests from 1 and 2, plus a second request from 1.
        do_reset();
        add_byte(1, 8'h11, 1'b1);
        add_byte(2, 8'h22, 1'b1);
        add_byte(1, 8'h5A, 1'b1);
        run("t2", 50);

        // Packet lock: source 3 waits for source 0's four-byte message.
        do_reset();
        add_byte(0, 8'hA0, 1'b0);
        add_byte(0, 8'hA1, 1'b0);
        add_byte(0, 8'hA2, 1'b0);
        add_byte(0, 8'hA3, 1'b1);
        add_byte(3, 8'h33, 1'b1);
        run("t3", 50);

        // Backpressure: 5 stalled cycles on byte 2 of a 3-byte message.
        do_reset();
        mode = 2;
        add_byte(1, 8'hB0, 1'b0);
        add_byte(1, 8'hB1, 1'b0);
        add_byte(1, 8'hB2, 1'b1);
        run("t4", 50);
        mode = 0;

        // Single-byte message from source 2 (header byte first when tagged).
        do_reset();
        add_byte(2, 8'h55, 1'b1);
        run("t5", 50);

        // Reset mid-DATA, then source 0 must win the next arbitration.
        do_reset();
        add_byte(2, 8'hC0, 1'b0);
        add_byte(2, 8'hC1, 1'b0);
        add_byte(2, 8'hC2, 1'b1);
        build_expected();
        beats_out     = 0;
        expect_bubble = 1'b1;
        repeat (TAGC + 2) step();
        #1;
        chk("t6_pre_busy", 32'(busy), 32'd1);
        aresetn = 1'b0;
        #1;
        chk("t6_async_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("t6_async_tdata", 32'(m_axis_tdata), 32'd0);
        chk("t6_async_tready", 32'(s_axis_tready), 32'd0);
        chk("t6_async_busy", 32'(busy), 32'd0);
        chk("t6_async_grant", 32'(grant_id), 32'd0);
        do_reset();
        add_byte(0, 8'h0D, 1'b1);
        run("t6", 50);

        // Randomized rounds with random backpressure and mid-message gaps.
        mode = 1;
        for (int r = 0; r < 4; r++) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                nm = $urandom_range(0, 3);
                for (int m = 0; m < nm; m++) begin
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++)
                        add_byte(s, 8'($urandom), (b == len - 1));
                end
            end
            run("rand", 3000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin, packet-locked arbiter that shares one `uart_tx` byte stream between `NUM_SRC` AXI-Stream byte producers (command responders, loopback echo, status reporter). It sits between the producers and the `uart_tx` slave port. Once a source is granted, it owns the UART until the beat carrying its `tlast` has been accepted, so multi-byte messages are never interleaved on the serial line.

## Interface
Parameters:
- `NUM_SRC`, 4: number of requesting sources; legal range 2..16.
- `ID_W`, `$clog2(NUM_SRC)`: width of the source index.

Ports:
- `aclk`  in  1  single clock for all logic.
- `aresetn`  in  1  reset; asynchronous assert, active-low.
- `s_axis_tvalid`  in  NUM_SRC  per-source valid.
- `s_axis_tdata`  in  NUM_SRC*8  per-source byte; source i occupies bits [8i+7:8i].
- `s_axis_tlast`  in  NUM_SRC  per-source end-of-message flag.
- `s_axis_tready`  out  NUM_SRC  per-source ready; one-hot or zero.
- `m_axis_tvalid`  out  1  byte valid toward `uart_tx`.
- `m_axis_tdata`  out  8  byte toward `uart_tx`.
- `m_axis_tready`  in  1  ready from `uart_tx`.
- `grant_id`  out  ID_W  index of the current or last granted source.
- `busy`  out  1  high whenever state != IDLE.

## Operation
- State machine with states IDLE, TAG and DATA. TAG exists only with the macro defined.
- IDLE:
  - Outputs: `m_axis_tvalid`=0 and `s_axis_tready`=0.
  - If any `s_axis_tvalid` is high, pick the first valid index searching upward from `last_grant+1`, modulo NUM_SRC.
  - Register that index into `grant_id`/`last_grant` and go to TAG (macro on) or DATA (macro off).
- TAG:
  - Drive `m_axis_tvalid`=1 and `m_axis_tdata`={4'hF, grant_id zero-extended to 4 bits}.
  - When `m_axis_tready`=1, go to DATA.
- DATA:
  - `m_axis_tvalid` = `s_axis_tvalid[grant_id]` and `m_axis_tdata` = the granted byte.
  - `s_axis_tready[grant_id]` = `m_axis_tready`; all other ready bits are 0.
  - When the granted source's tvalid, tlast and `m_axis_tready` are all high, go to IDLE.
- A granted source that drops tvalid mid-message keeps the grant indefinitely. No timeout.
- Non-granted sources are ignored. Their held data is the producer's responsibility under AXI rules.
- Reset values:
  - state=IDLE, `last_grant`=NUM_SRC-1 (the first search starts at 0), `grant_id`=0.
  - `busy`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0, `s_axis_tready`=0.
- Reset asserted mid-message abandons the message immediately. The remaining bytes of that source start a new, untagged-by-history grant after release.

## Timing
- Grant decision is registered: one bubble cycle (IDLE) between the last beat of one message and the first beat of the next.
- Minimum message overhead: 1 cycle without tag, 2 cycles with tag (at `m_axis_tready`=1).
- DATA-state paths `m_axis_tready`→`s_axis_tready` and `s_axis_tvalid`/`tdata`→`m_axis_*` are combinational.
- `m_axis_tvalid` never depends on `m_axis_tready` in the same cycle.
- Under backpressure, `m_axis_tdata` is stable while `m_axis_tvalid`=1 and `m_axis_tready`=0, given AXI-compliant sources.
- Simultaneous requests resolve in one cycle with no starvation. Each source waits at most NUM_SRC-1 messages.

## Configuration
- `UART_ARB_TAG_EN` defined:
  - TAG state is compiled in.
  - Every message is prefixed with one header byte 0xF0|id, so the host can demultiplex.
- Undefined: no TAG state; IDLE goes straight to DATA and the output stream is exactly the source bytes.

## Structure
- Shared package `uart_pkg`: `byte_t` typedef, the `arb_state_t` enum, and the `TAG_NIBBLE`=4'hF constant.
- One sub-module, `uart_rr_picker`:
  - Combinational round-robin picker with inputs `req[NUM_SRC]` and `last[ID_W]`, and outputs `found` and `idx[ID_W]`.
  - Reusable by other UART-side arbiters.

## Test plan
- Macro off; source 0 sends 0x41, 0x42, 0x43 (tlast on 0x43) with `m_axis_tready`=1 → output 0x41, 0x42, 0x43 on consecutive cycles after one idle cycle; `grant_id`=0; `busy` falls the cycle after 0x43.
- Sources 1 and 2 raise single-byte messages (0x11, 0x22) in the same cycle just after reset → 0x11 first, then 0x22; a new source 1 request while source 2 is pending waits for 0x22.
- Packet lock: source 0 is mid 4-byte message and source 3 asserts tvalid with 0x33 → 0x33 appears only after source 0's tlast beat, with one bubble.
- Backpressure: `m_axis_tready` held low 5 cycles during byte 2 of a 3-byte message → `m_axis_tdata` stable, `s_axis_tready` low, no byte lost or duplicated.
- `UART_ARB_TAG_EN` defined; source 2 sends 0x55 with tlast → output 0xF2, then 0x55.
- `aresetn` pulsed low mid-DATA → all outputs 0 asynchronously; after release, next request from source 0 is granted first.
